uart_program_loader: RTL and testbench



---
 rtl/uart_program_loader.sv | 171 +++++++++++++++++
 tb/tb_uart_program_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Boot loader that receives a length-prefixed program image over an 8N1 UART line,
// writes it into the 256x8 memory from address 0 with the CPU held in reset, then hands the memory port to the CPU.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic              i_load_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_data_write,
  input  logic              i_cpu_write_enable,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data_write,
  output logic              o_mem_write_enable,
  output logic              o_cpu_rstn,
  output logic              o_busy,
  output logic              o_frame_err
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = ADDR_W + 1;
  localparam logic [TIMER_W-1:0] HALF_M1 = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_M1 = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_WAIT_LEN, LD_LOAD, LD_DONE} ld_state_t;

  logic               rx_meta, rx_sync;
  rx_state_t          rx_state, rx_next;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               rx_valid;
  logic               timer_half, timer_full, stop_sample;

  ld_state_t          ld_state, ld_next;
  logic [ADDR_W-1:0]  load_addr;
  logic [7:0]         load_data;
  logic               load_we;
  logic [CNT_W-1:0]   count, len;
  logic               frame_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  assign timer_half  = (timer == HALF_M1);
  assign timer_full  = (timer == FULL_M1);
  assign stop_sample = (rx_state == RX_STOP) && timer_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (timer_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (timer_full && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (timer_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timer restarts at mid start bit, so data and stop samples land mid-bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= stop_sample && rx_sync;
      case (rx_state)
        RX_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
        end
        RX_START: timer <= timer_half ? '0 : timer + 1'b1;
        RX_DATA: begin
          if (timer_full) begin
            timer   <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: timer <= timer + 1'b1;
        default: timer <= '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ld_state <= LD_WAIT_LEN;
    else       ld_state <= ld_next;
  end

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_WAIT_LEN: if (rx_valid) ld_next = LD_LOAD;
      LD_LOAD:     if (load_we && count == len) ld_next = LD_DONE;
      LD_DONE:     if (i_load_req) ld_next = LD_WAIT_LEN;
      default:     ld_next = LD_WAIT_LEN;
    endcase
  end

  always_comb begin
    o_cpu_rstn  = (ld_state == LD_DONE);
    o_busy      = (ld_state != LD_DONE);
    o_frame_err = frame_err;
    if (ld_state == LD_DONE) begin
      o_mem_addr         = i_cpu_addr;
      o_mem_data_write   = i_cpu_data_write;
      o_mem_write_enable = i_cpu_write_enable;
    end else begin
      o_mem_addr         = load_addr;
      o_mem_data_write   = load_data;
      o_mem_write_enable = load_we;
    end
  end

  // load_addr holds the address of the pending strobe and advances once it has been written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      load_addr <= '0;
      load_data <= '0;
      load_we   <= 1'b0;
      count     <= '0;
      len       <= '0;
      frame_err <= 1'b0;
    end else begin
      load_we <= (ld_state == LD_LOAD) && rx_valid;
      if (ld_state == LD_DONE && i_load_req) frame_err <= 1'b0;
      else if (stop_sample && !rx_sync)      frame_err <= 1'b1;
      case (ld_state)
        LD_WAIT_LEN: begin
          if (rx_valid) begin
            len       <= (shift == 8'h00) ? CNT_W'(256) : CNT_W'(shift);
            load_addr <= '0;
            count     <= '0;
          end
        end
        LD_LOAD: begin
          if (rx_valid) begin
            load_data <= shift;
            count     <= count + 1'b1;
          end
          if (load_we) load_addr <= load_addr + 1'b1;
        end
        LD_DONE: if (i_load_req) load_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized bench for uart_program_loader: bytes are serialized onto i_rx and the
// observed memory writes / control outputs are compared with a byte-level loader model.
module tb_uart_program_loader;

  localparam int CPB = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_load_req = 1'b0;
  logic [7:0] i_cpu_addr = '0;
  logic [7:0] i_cpu_data_write = '0;
  logic       i_cpu_write_enable = 1'b0;
  logic [7:0] o_mem_addr;
  logic [7:0] o_mem_data_write;
  logic       o_mem_write_enable;
  logic       o_cpu_rstn;
  logic       o_busy;
  logic       o_frame_err;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_rx               (i_rx),
    .i_load_req         (i_load_req),
    .i_cpu_addr         (i_cpu_addr),
    .i_cpu_data_write   (i_cpu_data_write),
    .i_cpu_write_enable (i_cpu_write_enable),
    .o_mem_addr         (o_mem_addr),
    .o_mem_data_write   (o_mem_data_write),
    .o_mem_write_enable (o_mem_write_enable),
    .o_cpu_rstn         (o_cpu_rstn),
    .o_busy             (o_busy),
    .o_frame_err        (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Loader model: phase 0 = waiting for length, 1 = loading, 2 = done.
  int          m_phase = 0;
  int          m_rem   = 0;
  logic [7:0]  m_addr  = '0;
  logic        m_ferr  = 1'b0;
  logic [15:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ferr = 1'b1;
    end else begin
      case (m_phase)
        0: begin
          m_rem   = (b == 8'h00) ? 256 : int'(b);
          m_addr  = 8'h00;
          m_phase = 1;
        end
        1: begin
          exp_q.push_back({m_addr, b});
          m_addr = m_addr + 8'd1;
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
        default: ;
      endcase
    end
  endtask

  task automatic hold_line(input logic v, input int cycles, input bit rand_cpu);
    for (int c = 0; c < cycles; c++) begin
      i_rx = v;
      if (rand_cpu) begin
        i_cpu_addr         = 8'($urandom);
        i_cpu_data_write   = 8'($urandom);
        i_cpu_write_enable = 1'($urandom);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good, input bit rand_cpu);
    model_byte(b, good);
    hold_line(1'b0, CPB, rand_cpu);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB, rand_cpu);
    hold_line(good, CPB, rand_cpu);
    hold_line(1'b1, 2 * CPB, rand_cpu);
  endtask

  task automatic check_state(input string tag);
    check($sformatf("%s_rstn", tag), 32'(o_cpu_rstn), 32'(m_phase == 2));
    check($sformatf("%s_busy", tag), 32'(o_busy), 32'(m_phase != 2));
    check($sformatf("%s_ferr", tag), 32'(o_frame_err), 32'(m_ferr));
    check($sformatf("%s_pending_writes", tag), 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_req();
    bit was_done;
    was_done   = (m_phase == 2);
    i_load_req = 1'b1;
    @(negedge i_clk);
    i_load_req = 1'b0;
    if (was_done) begin
      m_phase = 0;
      m_ferr  = 1'b0;
    end
    #1;
    check_state("after_load_req");
    @(negedge i_clk);
  endtask

  // Write monitor: every loader strobe must match the next expected (addr, data).
  int          cyc = 0;
  int          last_wr = -100;
  logic        prev_we = 1'b0;
  logic        prev_rstn = 1'b0;
  logic [15:0] e;

  initial forever begin
    @(negedge i_clk);
    #1;
    cyc++;
    if (i_rst) begin
      prev_we   = 1'b0;
      prev_rstn = 1'b0;
    end else begin
      if (!o_cpu_rstn && o_mem_write_enable) begin
        check("write_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("write_addr", 32'(o_mem_addr), 32'(e[15:8]));
          check("write_data", 32'(o_mem_data_write), 32'(e[7:0]));
        end
        check("write_strobe_1cyc", 32'(prev_we), 32'd0);
        last_wr = cyc;
      end
      if (o_cpu_rstn && !prev_rstn) check("rstn_rise_latency", 32'(cyc - last_wr), 32'd1);
      if (o_cpu_rstn && !i_cpu_write_enable) check("done_no_loader_we", 32'(o_mem_write_enable), 32'd0);
      prev_we   = o_mem_write_enable && !o_cpu_rstn;
      prev_rstn = o_cpu_rstn;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int iter;
    logic [7:0] b;
    bit good;

    repeat (3) @(negedge i_clk);
    check("reset_rstn", 32'(o_cpu_rstn), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd1);
    check("reset_ferr", 32'(o_frame_err), 32'd0);
    check("reset_addr", 32'(o_mem_addr), 32'd0);
    check("reset_data", 32'(o_mem_data_write), 32'd0);
    check("reset_we", 32'(o_mem_write_enable), 32'd0);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);

    // One-cycle glitch on an idle line must not start a byte.
    i_rx = 1'b0;
    @(negedge i_clk);
    i_rx = 1'b1;
    repeat (3 * CPB) @(negedge i_clk);
    check_state("glitch");

    // Directed load with the CPU port toggling randomly throughout.
    send_byte(8'h03, 1'b1, 1'b1);
    send_byte(8'h19, 1'b1, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    send_byte(8'hC1, 1'b1, 1'b1);
    check_state("normal_load");

    // Pass-through in DONE: directed pattern then random ones.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        i_cpu_addr = 8'h10; i_cpu_data_write = 8'hAA; i_cpu_write_enable = 1'b1;
      end else begin
        i_cpu_addr = 8'($urandom); i_cpu_data_write = 8'($urandom); i_cpu_write_enable = 1'($urandom);
      end
      #1;
      check("pass_addr", 32'(o_mem_addr), 32'(i_cpu_addr));
      check("pass_data", 32'(o_mem_data_write), 32'(i_cpu_data_write));
      check("pass_we", 32'(o_mem_write_enable), 32'(i_cpu_write_enable));
      @(negedge i_clk);
    end
    i_cpu_write_enable = 1'b0;

    // Framing error in the middle of a load.
    pulse_req();
    send_byte(8'h02, 1'b1, 1'b1);
    send_byte(8'h55, 1'b0, 1'b1);
    send_byte(8'h66, 1'b1, 1'b1);
    send_byte(8'h77, 1'b1, 1'b1);
    check_state("frame_err_load");
    pulse_req();

    // Random images with occasional bad frames and a load request mid-load.
    for (int r = 0; r < 3; r++) begin
      if (r > 0) pulse_req();
      n = $urandom_range(1, 24);
      iter = 0;
      while (m_phase != 2 && iter < 200) begin
        good = ($urandom_range(0, 5) != 0);
        b = (m_phase == 0 && good) ? 8'(n) : 8'($urandom);
        send_byte(b, good, 1'b1);
        if (m_phase == 1 && iter == 2) pulse_req();
        iter++;
      end
      check_state($sformatf("random_load%0d", r));
    end

    // Full 256-byte image, then extra traffic in DONE.
    pulse_req();
    send_byte(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 256; k++) send_byte(8'($urandom), 1'b1, 1'b1);
    check_state("full_image");
    i_cpu_write_enable = 1'b0;
    send_byte(8'h5A, 1'b1, 1'b0);
    check_state("extra_byte_done");
    send_byte(8'hE7, 1'b0, 1'b0);
    check_state("frame_err_in_done");

    // Asynchronous reset mid-load, then a fresh load from address 0.
    pulse_req();
    send_byte(8'h03, 1'b1, 1'b1);
    send_byte(8'h5A, 1'b0, 1'b1);
    send_byte(8'hAB, 1'b1, 1'b1);
    repeat ($urandom_range(0, 10)) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    m_phase = 0;
    m_ferr  = 1'b0;
    check("midreset_rstn", 32'(o_cpu_rstn), 32'd0);
    check("midreset_busy", 32'(o_busy), 32'd1);
    check("midreset_ferr", 32'(o_frame_err), 32'd0);
    check("midreset_addr", 32'(o_mem_addr), 32'd0);
    check("midreset_data", 32'(o_mem_data_write), 32'd0);
    check("midreset_we", 32'(o_mem_write_enable), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    send_byte(8'h02, 1'b1, 1'b1);
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    check_state("after_midreset");

    repeat (4) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
